// File: rtl/dmem_pkg.sv
// Shared constants and the byte-lane merge helper for the data-side responder.
package dmem_pkg;

  localparam logic [11:0] OFF_MTIME_LO    = 12'h000;
  localparam logic [11:0] OFF_MTIME_HI    = 12'h004;
  localparam logic [11:0] OFF_MTIMECMP_LO = 12'h008;
  localparam logic [11:0] OFF_MTIMECMP_HI = 12'h00C;
  localparam logic [11:0] OFF_TOHOST      = 12'h010;
  localparam logic [11:0] OFF_GPIO_OUT    = 12'h014;
  localparam logic [11:0] OFF_ERR_STATUS  = 12'h018;

  localparam int ERR_UNMAPPED   = 0;
  localparam int ERR_BAD_OFFSET = 1;
  localparam int ERR_BITS       = 2;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic [31:0] merge(input logic [31:0] oldWord,
                                        input logic [31:0] newWord,
                                        input logic [3:0]  be);
    logic [31:0] res;
    res = oldWord;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = newWord[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_responder_mmio_timer.sv
// Prescaled 64-bit mtime with compare register and registered compare interrupt.
module mmio_timer
  import dmem_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mtimeLoWe,
  input  logic        mtimeHiWe,
  input  logic        cmpLoWe,
  input  logic        cmpHiWe,
  input  logic [3:0]  be,
  input  logic [31:0] wd,
  output logic [63:0] mtime,
  output logic [63:0] mtimecmp,
  output logic        timerIrq
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0] preCnt;
  logic          tick;
  logic [63:0]   mtimeInc;
  logic [63:0]   mtimeNext;
  logic [63:0]   cmpNext;

  // Written lanes override the incremented value; unwritten lanes keep counting.
  always_comb begin
    tick      = (preCnt == PRE_MAX);
    mtimeInc  = mtime + {63'd0, tick};
    mtimeNext = mtimeInc;
    cmpNext   = mtimecmp;
    if (mtimeLoWe) mtimeNext[31:0]  = merge(mtimeInc[31:0], wd, be);
    if (mtimeHiWe) mtimeNext[63:32] = merge(mtimeInc[63:32], wd, be);
    if (cmpLoWe)   cmpNext[31:0]    = merge(mtimecmp[31:0], wd, be);
    if (cmpHiWe)   cmpNext[63:32]   = merge(mtimecmp[63:32], wd, be);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      preCnt   <= '0;
      mtime    <= '0;
      mtimecmp <= MTIMECMP_RST;
      timerIrq <= 1'b0;
    end else begin
      preCnt   <= tick ? '0 : preCnt + 1'b1;
      mtime    <= mtimeNext;
      mtimecmp <= cmpNext;
      timerIrq <= (mtimeNext >= cmpNext);
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-side responder: word RAM at address 0 plus an MMIO page with timer,
// GPIO, tohost/halt and sticky error status.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000,
  parameter int          PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [3:0]  be,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        timer_irq,
  output logic [31:0] gpio_out,
  output logic        halt,
  output logic [31:0] tohost_val,
  output logic        err
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH) << 2;

  logic [31:0]         mem [DEPTH];
  logic                ramHit;
  logic                mmioHit;
  logic                unmapped;
  logic                offUsed;
  logic                wrAny;
  logic                mmioWr;
  logic [AW-1:0]       wordIdx;
  logic [11:0]         off;
  logic [63:0]         mtime;
  logic [63:0]         mtimecmp;
  logic [ERR_BITS-1:0] errStatus;
  logic [ERR_BITS-1:0] errSet;
  logic [ERR_BITS-1:0] errClr;
  logic [1:0]          unusedAddrBits;

  assign unusedAddrBits = a[1:0];

  // RAM takes priority should the MMIO page ever be placed inside it.
  assign ramHit   = ({1'b0, a} < RAM_BYTES);
  assign mmioHit  = !ramHit && (a[31:12] == MMIO_BASE[31:12]);
  assign unmapped = !ramHit && !mmioHit;
  assign wordIdx  = a[AW+1:2];
  assign off      = {a[11:2], 2'b00};
  assign offUsed  = (off <= OFF_ERR_STATUS);
  assign wrAny    = we && (be != 4'b0000);
  assign mmioWr   = we && mmioHit;

  assign errSet[ERR_UNMAPPED]   = wrAny && unmapped;
  assign errSet[ERR_BAD_OFFSET] = wrAny && mmioHit && !offUsed;
  assign errClr = (mmioWr && off == OFF_ERR_STATUS && be[0]) ? wd[ERR_BITS-1:0] : '0;

  mmio_timer #(
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .mtimeLoWe (mmioWr && off == OFF_MTIME_LO),
    .mtimeHiWe (mmioWr && off == OFF_MTIME_HI),
    .cmpLoWe   (mmioWr && off == OFF_MTIMECMP_LO),
    .cmpHiWe   (mmioWr && off == OFF_MTIMECMP_HI),
    .be        (be),
    .wd        (wd),
    .mtime     (mtime),
    .mtimecmp  (mtimecmp),
    .timerIrq  (timer_irq)
  );

  always_ff @(posedge clk) begin
    if (!rst && we && ramHit) mem[wordIdx] <= merge(mem[wordIdx], wd, be);
  end

  // A new error on a bit outranks a same-cycle W1C of that bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_out   <= '0;
      tohost_val <= '0;
      halt       <= 1'b0;
      errStatus  <= '0;
    end else begin
      if (mmioWr && off == OFF_GPIO_OUT) gpio_out <= merge(gpio_out, wd, be);
      if (mmioWr && off == OFF_TOHOST) begin
        tohost_val <= merge(tohost_val, wd, be);
        if (be != 4'b0000) halt <= 1'b1;
      end
      errStatus <= (errStatus & ~errClr) | errSet;
    end
  end

  assign err = |errStatus;

  always_comb begin
    rd = '0;
    if (ramHit) begin
      rd = mem[wordIdx];
    end else if (mmioHit) begin
      case (off)
        OFF_MTIME_LO:    rd = mtime[31:0];
        OFF_MTIME_HI:    rd = mtime[63:32];
        OFF_MTIMECMP_LO: rd = mtimecmp[31:0];
        OFF_MTIMECMP_HI: rd = mtimecmp[63:32];
        OFF_TOHOST:      rd = tohost_val;
        OFF_GPIO_OUT:    rd = gpio_out;
        OFF_ERR_STATUS:  rd = {{(32-ERR_BITS){1'b0}}, errStatus};
        default:         rd = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a behavioural memory-map model.
module tb_dmem_responder;

  localparam int          DEPTH     = 1024;
  localparam logic [31:0] MMIO_BASE = 32'h8000_0000;
  localparam int          PRESCALE  = 1;
  localparam logic [31:0] MB        = MMIO_BASE;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [31:0] a = '0;
  logic [3:0]  be = '0;
  logic [31:0] wd = '0;
  logic [31:0] rd;
  logic        timer_irq;
  logic [31:0] gpio_out;
  logic        halt;
  logic [31:0] tohost_val;
  logic        err;

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH     (DEPTH),
    .MMIO_BASE (MMIO_BASE),
    .PRESCALE  (PRESCALE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .a          (a),
    .be         (be),
    .wd         (wd),
    .rd         (rd),
    .timer_irq  (timer_irq),
    .gpio_out   (gpio_out),
    .halt       (halt),
    .tohost_val (tohost_val),
    .err        (err)
  );

  int nCompared = 0;
  int nMismatched = 0;

  // reference state of the whole memory map
  logic [63:0] mMtime;
  logic [63:0] mCmp;
  logic [31:0] mGpio;
  logic [31:0] mTohost;
  logic        mHalt;
  logic [1:0]  mErr;
  int          mPre;
  logic [31:0] mRam [int];

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] laneMix(input logic [31:0] oldW, input logic [31:0] newW,
                                          input logic [3:0] bytes);
    logic [31:0] r;
    r = oldW;
    for (int i = 0; i < 4; i++) if (bytes[i]) r[8*i +: 8] = newW[8*i +: 8];
    return r;
  endfunction

  function automatic bit isRam(input logic [31:0] addr);
    return addr < 32'(DEPTH * 4);
  endfunction

  function automatic bit isMmio(input logic [31:0] addr);
    return !isRam(addr) && ((addr & 32'hFFFF_F000) == MMIO_BASE);
  endfunction

  task automatic modelReset();
    mMtime = '0; mCmp = '1; mGpio = '0; mTohost = '0; mHalt = 1'b0; mErr = '0; mPre = 0;
  endtask

  task automatic modelRead(input logic [31:0] addr, output logic [31:0] v, output bit known);
    int idx;
    known = 1'b1;
    v = '0;
    idx = int'(addr >> 2);
    if (isRam(addr)) begin
      if (mRam.exists(idx)) v = mRam[idx];
      else known = 1'b0;
    end else if (isMmio(addr)) begin
      case (addr & 32'h0000_0FFC)
        32'h000: v = mMtime[31:0];
        32'h004: v = mMtime[63:32];
        32'h008: v = mCmp[31:0];
        32'h00C: v = mCmp[63:32];
        32'h010: v = mTohost;
        32'h014: v = mGpio;
        32'h018: v = {30'd0, mErr};
        default: v = '0;
      endcase
    end
  endtask

  task automatic modelClock(input bit w, input logic [31:0] addr, input logic [3:0] bytes,
                            input logic [31:0] data);
    bit tick;
    int idx;
    tick = (mPre == PRESCALE - 1);
    mPre = tick ? 0 : mPre + 1;
    mMtime = mMtime + (tick ? 64'd1 : 64'd0);
    idx = int'(addr >> 2);
    if (w) begin
      if (isRam(addr)) begin
        mRam[idx] = laneMix(mRam.exists(idx) ? mRam[idx] : 32'd0, data, bytes);
      end else if (isMmio(addr)) begin
        case (addr & 32'h0000_0FFC)
          32'h000: mMtime[31:0]  = laneMix(mMtime[31:0], data, bytes);
          32'h004: mMtime[63:32] = laneMix(mMtime[63:32], data, bytes);
          32'h008: mCmp[31:0]    = laneMix(mCmp[31:0], data, bytes);
          32'h00C: mCmp[63:32]   = laneMix(mCmp[63:32], data, bytes);
          32'h010: begin
            mTohost = laneMix(mTohost, data, bytes);
            if (bytes != 4'b0000) mHalt = 1'b1;
          end
          32'h014: mGpio = laneMix(mGpio, data, bytes);
          32'h018: if (bytes[0]) mErr = mErr & ~data[1:0];
          default: if (bytes != 4'b0000) mErr[1] = 1'b1;
        endcase
      end else if (bytes != 4'b0000) begin
        mErr[0] = 1'b1;
      end
    end
  endtask

  task automatic checkOuts();
    checkVal("timer_irq", timer_irq, mMtime >= mCmp);
    checkVal("gpio_out", gpio_out, mGpio);
    checkVal("halt", halt, mHalt);
    checkVal("tohost_val", tohost_val, mTohost);
    checkVal("err", err, |mErr);
  endtask

  // Entered and left at posedge+1: checks rd before the edge, outputs after it.
  task automatic step(input bit w, input logic [31:0] addr, input logic [3:0] bytes,
                      input logic [31:0] data);
    logic [31:0] e;
    bit k;
    we = w; a = addr; be = bytes; wd = data;
    #1;
    modelRead(addr, e, k);
    if (k) checkVal("rd", rd, e);
    @(posedge clk);
    modelClock(w, addr, bytes, data);
    #1;
    checkOuts();
  endtask

  task automatic doReset();
    rst = 1'b1; we = 1'b0; be = '0;
    @(posedge clk);
    modelReset();
    #1;
    rst = 1'b0;
    checkOuts();
  endtask

  initial begin
    logic [31:0] hiBefore;
    logic [31:0] addr;
    bit found;
    int op;
    int widx;

    doReset();
    step(1'b0, MB + 32'h0, 4'h0, 32'h0);
    step(1'b0, MB + 32'h8, 4'h0, 32'h0);

    for (int i = 0; i <= 32; i++) begin
      widx = (i == 32) ? DEPTH - 1 : i;
      step(1'b1, 32'(widx * 4), 4'hF, $urandom);
    end

    // RAM byte lane and be=0
    step(1'b1, 32'h10, 4'hF, 32'h1122_3344);
    step(1'b1, 32'h10, 4'b0100, 32'h00AB_0000);
    step(1'b0, 32'h10, 4'h0, 32'h0);
    checkVal("ram_byte", rd, 32'h11AB_3344);
    step(1'b1, 32'h12, 4'h0, 32'hFFFF_FFFF);
    step(1'b0, 32'h10, 4'h0, 32'h0);
    checkVal("ram_be0", rd, 32'h11AB_3344);
    checkVal("ram_be0_err", err, 1'b0);

    // unmapped write then W1C
    step(1'b1, 32'h4000_0000, 4'hF, 32'hDEAD_BEEF);
    checkVal("unmapped_err", err, 1'b1);
    step(1'b0, MB + 32'h18, 4'h0, 32'h0);
    checkVal("err_status", rd, 32'h1);
    step(1'b0, 32'h4000_0000, 4'h0, 32'h0);
    checkVal("unmapped_rd", rd, 32'h0);
    step(1'b0, 32'h0, 4'h0, 32'h0);
    step(1'b1, MB + 32'h18, 4'hF, 32'h1);
    checkVal("w1c_err", err, 1'b0);

    // compare interrupt
    doReset();
    step(1'b1, MB + 32'hC, 4'hF, 32'h0);
    step(1'b1, MB + 32'h8, 4'hF, 32'd20);
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      step(1'b0, MB + 32'h0, 4'h0, 32'h0);
      if (timer_irq) begin
        checkVal("irq_rise_mtime", rd, 32'd20);
        found = 1'b1;
      end
    end
    checkVal("irq_rise_timeout", found, 1'b1);
    step(1'b1, MB + 32'h8, 4'hF, 32'hFFFF_FFFF);
    step(1'b1, MB + 32'hC, 4'hF, 32'hFFFF_FFFF);
    checkVal("irq_clear", timer_irq, 1'b0);

    // write/increment collision and carry into the high half
    step(1'b1, MB + 32'h0, 4'hF, 32'hFFFF_FFF0);
    step(1'b0, MB + 32'h0, 4'h0, 32'h0);
    checkVal("mtime_lo_collision", rd, 32'hFFFF_FFF1);
    hiBefore = mMtime[63:32];
    step(1'b1, MB + 32'h0, 4'hF, 32'hFFFF_FFFF);
    step(1'b0, MB + 32'h4, 4'h0, 32'h0);
    checkVal("mtime_hi_carry", rd, hiBefore + 32'd1);
    step(1'b1, MB + 32'h0, 4'b0010, 32'h0000_5500);
    step(1'b0, MB + 32'h0, 4'h0, 32'h0);

    // tohost, gpio, reset
    step(1'b1, MB + 32'h10, 4'hF, 32'h1);
    checkVal("halt_set", halt, 1'b1);
    checkVal("tohost_set", tohost_val, 32'h1);
    step(1'b1, MB + 32'h14, 4'hF, 32'hA5A5_A5A5);
    checkVal("gpio_set", gpio_out, 32'hA5A5_A5A5);
    checkVal("halt_sticky", halt, 1'b1);
    doReset();
    checkVal("rst_gpio", gpio_out, 32'h0);
    checkVal("rst_halt", halt, 1'b0);
    checkVal("rst_tohost", tohost_val, 32'h0);
    checkVal("rst_irq", timer_irq, 1'b0);
    checkVal("rst_err", err, 1'b0);

    // unused offset error, W1C, then set racing a forced clear
    step(1'b1, MB + 32'h1C, 4'hF, 32'h0);
    checkVal("bad_off_err", err, 1'b1);
    step(1'b1, MB + 32'h18, 4'hF, 32'h2);
    checkVal("w1c_bit1", err, 1'b0);
    force dut.errClr = 2'b10;
    step(1'b1, MB + 32'h1C, 4'hF, 32'h0);
    release dut.errClr;
    step(1'b0, MB + 32'h18, 4'h0, 32'h0);
    checkVal("set_wins", rd, 32'h2);

    for (int n = 0; n < 2000; n++) begin
      op = int'($urandom_range(0, 9));
      widx = int'($urandom_range(0, 32));
      if (widx == 32) widx = DEPTH - 1;
      case (op)
        0, 1, 2: step(1'b1, 32'(widx * 4) | 32'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), $urandom);
        3:       step(1'b0, 32'(widx * 4) | 32'($urandom_range(0, 3)), 4'h0, $urandom);
        4, 5: begin
          addr = ($urandom_range(0, 15) == 0) ? MB + 32'hFFC : MB + 32'($urandom_range(0, 8) * 4);
          step(1'b1, addr | 32'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), $urandom);
        end
        6:       step(1'b0, MB + 32'($urandom_range(0, 9) * 4), 4'h0, 32'h0);
        7, 8: begin
          case ($urandom_range(0, 3))
            0:       addr = 32'(DEPTH * 4) + 32'($urandom_range(0, 3));
            1:       addr = 32'h4000_0000 | ($urandom & 32'h3FFF_FFFF);
            2:       addr = MB + 32'h1000 + 32'($urandom_range(0, 255));
            default: addr = MB - 32'd4;
          endcase
          step(op == 7, addr, 4'($urandom_range(0, 15)), $urandom);
        end
        default: step(1'b0, 32'h0, 4'h0, 32'h0);
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-side responder for the pipelined RV32I core's memory-stage port.
- Serves the core's combinational-read / clocked-write data interface with byte-lane enables, using lane-aligned write data (the core pre-rotates it).
- Decodes two regions: a word-organised RAM at address 0 and a small MMIO page. The MMIO page holds a prescaled 64-bit timer with compare interrupt, a GPIO output register, a tohost/halt register and a sticky error status.
- Replaces the plain data memory at the top level.

Parameters:
- DEPTH, 1024, RAM size in 32-bit words; power of two.
- MMIO_BASE, 32'h8000_0000, base address of the 4 KiB MMIO page.
- PRESCALE, 1, clk cycles per mtime increment; must be ≥1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- we  in  1  write strobe, sampled at posedge clk.
- a  in  32  byte address; bits [1:0] are ignored for decode and indexing.
- be  in  4  byte-lane enables; be[i] covers wd/rd bits [8i+7:8i].
- wd  in  32  lane-aligned write data.
- rd  out  32  combinational read data for the word at a[31:2].
- timer_irq  out  1  high while mtime ≥ mtimecmp (unsigned 64-bit compare).
- gpio_out  out  32  GPIO register contents.
- halt  out  1  sticky; set by any write to TOHOST.
- tohost_val  out  32  last value written to TOHOST.
- err  out  1  OR of the ERR_STATUS bits.

Behaviour:
- Single clock domain. Reset is synchronous active-high and is evaluated before any write in the same cycle.
- Reset values: mtime=0, prescaler=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, gpio_out=0, tohost_val=0, halt=0, ERR_STATUS=0. This gives timer_irq=0 and err=0 out of reset.
- RAM contents are not reset.
- Decode:
  - RAM hit: a < DEPTH*4.
  - MMIO hit: a[31:12] == MMIO_BASE[31:12].
  - Anything else: unmapped.
- Read path:
  - rd is purely combinational from a; zero-cycle latency; no read strobe.
  - RAM hit returns mem[a[log2(DEPTH)+1:2]].
  - Unmapped addresses and unused MMIO offsets return 0. Reads never change state.
- Write, RAM: on posedge with we=1 and a RAM hit, each lane i with be[i]=1 takes wd lane i; other lanes are unchanged. be=0 means no change and no error.
- MMIO register map (word offsets):
  - 0x00 MTIME_LO, R/W.
  - 0x04 MTIME_HI, R/W.
  - 0x08 MTIMECMP_LO, R/W.
  - 0x0C MTIMECMP_HI, R/W.
  - 0x10 TOHOST, R/W.
  - 0x14 GPIO_OUT, R/W.
  - 0x18 ERR_STATUS, W1C: bit0 = unmapped write, bit1 = unused-MMIO-offset write.
- All MMIO writes honour be per lane. TOHOST sets halt=1 on any write with be≠0.
- Timer:
  - The prescaler counts 0..PRESCALE-1. mtime increments by 1 in the cycle the prescaler wraps. With PRESCALE=1, mtime increments every cycle.
  - mtime wraps from 2^64-1 to 0.
  - A write to either MTIME half in the same cycle as an increment: the written lanes take wd, the other lanes take the incremented value. The write does not reset the prescaler.
  - timer_irq is registered and is computed from the next-state mtime and mtimecmp, so it reflects any write on the following cycle.
- Errors:
  - A write with be≠0 to an unmapped address is ignored and sets bit0.
  - A write with be≠0 to an unused MMIO offset is ignored and sets bit1.
  - A W1C write and a new error on the same bit in the same cycle: the set wins.
- halt does not gate any logic in this block; the testbench or top level consumes it.

Decomposition:
- Shared package dmem_pkg holds:
  - MMIO offset localparams (OFF_MTIME_LO … OFF_ERR_STATUS);
  - ERR bit indices;
  - the mtimecmp reset constant;
  - a byte-lane merge function, merge(old, new, be), reused by the RAM and by every MMIO register.
- One sub-module: mmio_timer, containing the prescaler, the 64-bit mtime, mtimecmp and the registered irq, with per-half write ports.
- RAM, decode and the remaining registers stay in dmem_responder.

Test Plan:
- RAM byte write: we=1, a=0x10, be=4'b0100, wd=0x00AB_0000 over an existing 0x1122_3344 → next cycle rd at 0x10 = 0x11AB_3344. be=0 leaves the word unchanged and err=0.
- Unmapped write: we=1, a=0x4000_0000, be=4'hF → no RAM word changes, err=1, ERR_STATUS=0x1, rd at that address = 0. Then write 0x1 to MMIO_BASE+0x18 → err=0.
- Timer irq with PRESCALE=1:
  - After rst, write MTIMECMP_HI=0 then MTIMECMP_LO=20 → timer_irq rises in the cycle mtime first reads ≥20.
  - Write MTIMECMP_LO=0xFFFF_FFFF, MTIMECMP_HI=0xFFFF_FFFF → timer_irq=0 next cycle.
- Write/increment collision: write MTIME_LO=0xFFFF_FFF0 with be=4'hF while counting → next read = 0xFFFF_FFF1 or later. Write MTIME_LO=0xFFFF_FFFF → MTIME_HI increments at the wrap.
- TOHOST: write 0x0000_0001 → halt=1 and tohost_val=1. A subsequent GPIO write of 0xA5A5_A5A5 → gpio_out=0xA5A5_A5A5 and halt stays 1. Assert rst one cycle → all outputs return to their reset values.
- Same-cycle W1C vs set: write ERR_STATUS=0x2 while bit1 is set; in the next cycle write an unused offset 0x1C, with a W1C write 0x2 forced in the same cycle via a bench override → bit1 remains 1.
